// File: rtl/shuf_pkg.sv
// Shared constants and types for the shuffle-select arbiter and its decoder.
package shuf_pkg;

    localparam int unsigned SHUF_W       = 64;
    localparam int unsigned SHUF_LANES   = 8;
    localparam int unsigned SHUF_FIELD_W = 3;

    typedef logic [SHUF_W-1:0] shuf_word_t;

endpackage

// File: rtl/shuf_decode.sv
// Combinational shuffle-select decoder: each 8-bit lane's low 3-bit field picks one
// output bit of that lane, rotated by the lane index.
module shuf_decode
    import shuf_pkg::*;
(
    input  shuf_word_t word_i,
    output shuf_word_t sel_o
);

    always_comb begin
        sel_o = '0;
        for (int k = 0; k < int'(SHUF_LANES); k++) begin
            for (int j = 0; j < int'(SHUF_LANES); j++) begin
                // Bit j of lane k is set when the field equals (k - j) mod 8.
                sel_o[SHUF_LANES*k + j] =
                    (word_i[SHUF_LANES*k +: SHUF_FIELD_W] == SHUF_FIELD_W'((k - j) & 7));
            end
        end
    end

endmodule

// File: rtl/shuf_arb.sv
// Round-robin arbiter sharing one shuffle decoder among NREQ requesters; the decoded
// select vector and winner ID are registered behind a valid/ready output stage.
module shuf_arb
    import shuf_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int unsigned CNTW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*64-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [63:0]        out_sel,
    output logic [IDW-1:0]     out_id,
    output logic [CNTW-1:0]    acc_cnt
);

    logic            valid_q;
    shuf_word_t      sel_q;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  rr_q;
    logic [CNTW-1:0] cnt_q;

    logic            ld;
    logic            found;
    logic            accept;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  cand;
    shuf_word_t      win_word;
    shuf_word_t      win_sel;

    assign ld = !valid_q || out_ready;

    // Scan starts at rr_q and wraps; the first valid requester wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int off = 0; off < int'(NREQ); off++) begin
            cand = IDW'((int'(rr_q) + off) % int'(NREQ));
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && ld && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign accept   = |req_ready;
    assign win_word = req_data[SHUF_W*int'(winner) +: SHUF_W];

    shuf_decode u_decode (
        .word_i (win_word),
        .sel_o  (win_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            id_q    <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else if (ld) begin
            if (accept) begin
                valid_q <= 1'b1;
                sel_q   <= win_sel;
                id_q    <= winner;
                rr_q    <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_sel   = sel_q;
    assign out_id    = id_q;
    assign acc_cnt   = cnt_q;

endmodule

// File: tb/tb_shuf_arb.sv
// Scoreboard bench for shuf_arb: a cycle model predicts grants, pushes expected results
// and pops them as the DUT retires each output.
module tb_shuf_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;
    localparam int CMAX = 15;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*64-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [63:0]        out_sel;
    logic [IDW-1:0]     out_id;
    logic [CNTW-1:0]    acc_cnt;

    logic [63:0] data [NREQ];

    shuf_arb #(
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .out_id    (out_id),
        .acc_cnt   (acc_cnt)
    );

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_data[64*i +: 64] = data[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          m_rr;
    bit          m_outv;
    logic [63:0] m_sel;
    int          m_id;
    int          m_cnt;
    logic [63:0] q_sel [$];
    int          q_id  [$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_decode(input logic [63:0] w);
        logic [63:0] r;
        int          f;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            f = int'(w[8*k +: 3]);
            r[8*k + ((k - f) & 7)] = 1'b1;
        end
        return r;
    endfunction

    // One clock: check grants before the edge, update model, check outputs after it.
    task automatic step();
        int          win;
        logic [3:0]  exp_rdy;
        bit          ld;
        @(negedge clk);
        win     = -1;
        exp_rdy = '0;
        ld      = !m_outv || out_ready;
        if (rst_n && ld) begin
            for (int off = 0; off < NREQ; off++) begin
                if (win < 0 && req_valid[(m_rr + off) % NREQ]) win = (m_rr + off) % NREQ;
            end
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
        check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (rst_n && m_outv && out_ready) begin
            if (q_sel.size() > 0) begin
                check_eq("retire_sel", out_sel, q_sel.pop_front());
                check_eq("retire_id", 64'(out_id), 64'(q_id.pop_front()));
            end else begin
                check_eq("retire_qsize", 64'(q_sel.size()), 64'd1);
            end
        end
        if (win >= 0) begin
            q_sel.push_back(ref_decode(data[win]));
            q_id.push_back(win);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_outv = 1'b0;
            m_sel  = '0;
            m_id   = 0;
            m_rr   = 0;
            m_cnt  = 0;
            q_sel.delete();
            q_id.delete();
        end else if (ld) begin
            if (win >= 0) begin
                m_outv = 1'b1;
                m_sel  = ref_decode(data[win]);
                m_id   = win;
                m_rr   = (win + 1) % NREQ;
                if (m_cnt < CMAX) m_cnt++;
            end else begin
                m_outv = 1'b0;
            end
        end
        check_eq("out_valid", 64'(out_valid), 64'(m_outv));
        check_eq("out_sel", out_sel, m_sel);
        check_eq("out_id", 64'(out_id), 64'(m_id));
        check_eq("acc_cnt", 64'(acc_cnt), 64'(m_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_ids [5];
        rr_ids = '{0, 1, 2, 3, 0};
        m_rr = 0; m_outv = 1'b0; m_sel = '0; m_id = 0; m_cnt = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) data[i] = '0;
        step();
        step();
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_sel", out_sel, 64'd0);
        check_eq("rst_cnt", 64'(acc_cnt), 64'd0);

        // Single request from requester 0
        rst_n     = 1'b1;
        req_valid = 4'b0001;
        step();
        check_eq("t1_sel", out_sel, 64'h8040_2010_0804_0201);
        check_eq("t1_id", 64'(out_id), 64'd0);
        check_eq("t1_cnt", 64'(acc_cnt), 64'd1);
        req_valid = '0;
        step();
        out_ready = 1'b1;
        step();

        // Decode with and without ignored upper bits
        data[2]   = 64'h0707_0707_0707_0707;
        req_valid = 4'b0100;
        step();
        check_eq("dec_sel", out_sel, 64'h0180_4020_1008_0402);
        check_eq("dec_id", 64'(out_id), 64'd2);
        data[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        check_eq("dec_hi_sel", out_sel, 64'h0180_4020_1008_0402);
        req_valid = '0;
        step();

        // Round robin from a fresh pointer
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) data[i] = {8{8'(i)}};
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("rr_id", 64'(out_id), 64'(rr_ids[i]));
        end

        // Backpressure: result held, grants blocked, then reload on release
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_id", 64'(out_id), 64'd0);
            check_eq("bp_ready", 64'(req_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        check_eq("bp_next_id", 64'(out_id), 64'd1);

        // Counter saturation
        for (int i = 0; i < 20; i++) step();
        check_eq("sat_cnt", 64'(acc_cnt), 64'hF);

        // Reset while a result is valid
        rst_n = 1'b0;
        step();
        check_eq("mrst_valid", 64'(out_valid), 64'd0);
        check_eq("mrst_cnt", 64'(acc_cnt), 64'd0);
        rst_n = 1'b1;
        step();
        check_eq("mrst_id", 64'(out_id), 64'd0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            for (int r = 0; r < NREQ; r++) data[r] = {$urandom, $urandom};
            step();
        end

        // Drain
        req_valid = '0;
        out_ready = 1'b1;
        step();
        step();
        check_eq("drain_qsize", 64'(q_sel.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
